// File: rtl/rc_failsafe_arming_pkg.sv
// Shared types and constants for the RC arming gate / loss-of-signal failsafe.
// State encodings are fixed because fsm_state is read back over UART/LED debug.
package rc_failsafe_arming_pkg;

    localparam int unsigned REC_VAL_BIT_WIDTH = 8;

    typedef logic [REC_VAL_BIT_WIDTH-1:0] rec_val_t;

    localparam rec_val_t NEUTRAL_VAL = rec_val_t'(125);

    typedef enum logic [2:0] {
        FsDisarmed = 3'd0,
        FsArming   = 3'd1,
        FsArmed    = 3'd2,
        FsFailsafe = 3'd3,
        FsLockout  = 3'd4
    } fs_state_e;

    // Compare a receiver channel against a 32-bit threshold without truncating either side.
    function automatic logic rec_at_least(input rec_val_t val, input int unsigned thresh);
        return 32'(val) >= thresh;
    endfunction

    function automatic logic rec_at_most(input rec_val_t val, input int unsigned limit);
        return 32'(val) <= limit;
    endfunction

endpackage

// File: rtl/rc_failsafe_arming_if.sv
// Receiver-side channels into the arming gate and the gated stick/status outputs.
// master = receiver / flight pipeline side, slave = rc_failsafe_arming.
interface rc_failsafe_arming_if;
    import rc_failsafe_arming_pkg::*;

    logic     throttle_pwm;
    rec_val_t throttle_val;
    rec_val_t yaw_val;
    rec_val_t roll_val;
    rec_val_t pitch_val;
    rec_val_t swa_swb_val;
    logic     imu_good;

    rec_val_t throttle_out;
    rec_val_t yaw_out;
    rec_val_t roll_out;
    rec_val_t pitch_out;
    logic     armed;
    logic     failsafe_active;
    logic     signal_ok;
    logic [2:0] fsm_state;

    modport master (
        output throttle_pwm, throttle_val, yaw_val, roll_val, pitch_val, swa_swb_val, imu_good,
        input  throttle_out, yaw_out, roll_out, pitch_out, armed, failsafe_active, signal_ok,
               fsm_state
    );

    modport slave (
        input  throttle_pwm, throttle_val, yaw_val, roll_val, pitch_val, swa_swb_val, imu_good,
        output throttle_out, yaw_out, roll_out, pitch_out, armed, failsafe_active, signal_ok,
               fsm_state
    );

endinterface

// File: rtl/rc_signal_monitor.sv
// Receiver signal-presence monitor: synchronizes the raw throttle pulse, detects
// rising edges and flags loss of signal after SIGNAL_TIMEOUT_US edge-free cycles.
module rc_signal_monitor #(
    parameter int unsigned SIGNAL_TIMEOUT_US = 50000
) (
    input  logic us_clk,
    input  logic resetn,
    input  logic throttle_pwm,
    output logic signal_ok
);

    localparam int unsigned CntW = $clog2(SIGNAL_TIMEOUT_US + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SIGNAL_TIMEOUT_US);

    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    logic            pwm_rise;
    logic [CntW-1:0] cnt_q;
    logic            signal_ok_q;

    assign pwm_rise  = sync2_q & ~prev_q;
    assign signal_ok = signal_ok_q;

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            signal_ok_q <= 1'b0;
        end else begin
            sync1_q <= throttle_pwm;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // Saturates at the timeout so a long outage never wraps back to "signal present".
            if (pwm_rise) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            signal_ok_q <= (cnt_q < CntMax);
        end
    end

endmodule

// File: rtl/rc_failsafe_arming.sv
// Arming gate and loss-of-signal failsafe between the receiver and the flight pipeline.
// Sticks pass only while armed; signal loss ramps throttle to zero and locks out.
module rc_failsafe_arming
    import rc_failsafe_arming_pkg::*;
#(
    parameter int unsigned SIGNAL_TIMEOUT_US = 50000,
    parameter int unsigned ARM_HOLD_US       = 1000000,
    parameter int unsigned THROTTLE_ARM_MAX  = 10,
    parameter int unsigned ARM_SWITCH_THRESH = 128,
    parameter int unsigned DESCENT_STEP_US   = 20000
) (
    input logic           us_clk,
    input logic           resetn,
    rc_failsafe_arming_if.slave rc
);

    localparam int unsigned HoldW = $clog2(ARM_HOLD_US + 1);
    localparam int unsigned StepW = $clog2(DESCENT_STEP_US + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ARM_HOLD_US - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(DESCENT_STEP_US - 1);

    logic             signal_ok;
    logic             switch_on;
    logic             arm_ok;

    fs_state_e        state_q;
    logic [HoldW-1:0] hold_q;
    logic [StepW-1:0] step_q;
    rec_val_t         throttle_q;
    rec_val_t         yaw_q;
    rec_val_t         roll_q;
    rec_val_t         pitch_q;
    logic             armed_q;
    logic             failsafe_q;

    rc_signal_monitor #(
        .SIGNAL_TIMEOUT_US(SIGNAL_TIMEOUT_US)
    ) u_signal_monitor (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .throttle_pwm(rc.throttle_pwm),
        .signal_ok   (signal_ok)
    );

    assign switch_on = rec_at_least(rc.swa_swb_val, ARM_SWITCH_THRESH);
    assign arm_ok    = signal_ok & rc.imu_good & switch_on
                     & rec_at_most(rc.throttle_val, THROTTLE_ARM_MAX);

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state_q    <= FsDisarmed;
            hold_q     <= '0;
            step_q     <= '0;
            throttle_q <= '0;
            yaw_q      <= NEUTRAL_VAL;
            roll_q     <= NEUTRAL_VAL;
            pitch_q    <= NEUTRAL_VAL;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
        end else begin
            // Sticks are neutral and flags low unless a branch below says otherwise.
            yaw_q      <= NEUTRAL_VAL;
            roll_q     <= NEUTRAL_VAL;
            pitch_q    <= NEUTRAL_VAL;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
            unique case (state_q)
                FsDisarmed: begin
                    throttle_q <= '0;
                    hold_q     <= '0;
                    if (arm_ok) state_q <= FsArming;
                end
                FsArming: begin
                    throttle_q <= '0;
                    if (!arm_ok) begin
                        state_q <= FsDisarmed;
                        hold_q  <= '0;
                    end else if (hold_q == HoldLast) begin
                        state_q    <= FsArmed;
                        armed_q    <= 1'b1;
                        throttle_q <= rc.throttle_val;
                        yaw_q      <= rc.yaw_val;
                        roll_q     <= rc.roll_val;
                        pitch_q    <= rc.pitch_val;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                FsArmed: begin
                    if (!signal_ok) begin
                        // throttle_q keeps the last passed value as the ramp start.
                        state_q    <= FsFailsafe;
                        failsafe_q <= 1'b1;
                        step_q     <= '0;
                    end else if (!switch_on) begin
                        state_q    <= FsDisarmed;
                        throttle_q <= '0;
                    end else begin
                        armed_q    <= 1'b1;
                        throttle_q <= rc.throttle_val;
                        yaw_q      <= rc.yaw_val;
                        roll_q     <= rc.roll_val;
                        pitch_q    <= rc.pitch_val;
                    end
                end
                FsFailsafe: begin
                    // Signal return and switch-off are deliberately ignored until the ramp ends.
                    if (throttle_q == '0) begin
                        state_q <= FsLockout;
                    end else begin
                        failsafe_q <= 1'b1;
                        if (step_q == StepLast) begin
                            step_q     <= '0;
                            throttle_q <= throttle_q - 1'b1;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                FsLockout: begin
                    throttle_q <= '0;
                    if (signal_ok && !switch_on) state_q <= FsDisarmed;
                end
                default: begin
                    state_q    <= FsDisarmed;
                    throttle_q <= '0;
                end
            endcase
        end
    end

    assign rc.throttle_out    = throttle_q;
    assign rc.yaw_out         = yaw_q;
    assign rc.roll_out        = roll_q;
    assign rc.pitch_out       = pitch_q;
    assign rc.armed           = armed_q;
    assign rc.failsafe_active = failsafe_q;
    assign rc.signal_ok       = signal_ok;
    assign rc.fsm_state       = state_q;

endmodule

// File: tb/tb_rc_failsafe_arming.sv
// Randomized bench for rc_failsafe_arming against a timestamp-based reference model,
// with directed arming, failsafe ramp, lockout and reset scenarios.
module tb_rc_failsafe_arming;

    localparam int unsigned Timeout   = 40;
    localparam int unsigned Hold      = 60;
    localparam int unsigned ThrMax    = 10;
    localparam int unsigned SwThresh  = 128;
    localparam int unsigned Step      = 3;
    localparam int          PwmPeriod = 20;

    localparam int MDisarmed = 0;
    localparam int MArming   = 1;
    localparam int MArmed    = 2;
    localparam int MFailsafe = 3;
    localparam int MLockout  = 4;
    localparam int Neutral   = 125;

    logic us_clk = 1'b0;
    logic resetn;

    rc_failsafe_arming_if rc ();

    rc_failsafe_arming #(
        .SIGNAL_TIMEOUT_US(Timeout),
        .ARM_HOLD_US      (Hold),
        .THROTTLE_ARM_MAX (ThrMax),
        .ARM_SWITCH_THRESH(SwThresh),
        .DESCENT_STEP_US  (Step)
    ) dut (
        .us_clk(us_clk),
        .resetn(resetn),
        .rc    (rc)
    );

    always #5 us_clk = ~us_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: signal age since the last clearing edge, arm start and failsafe
    // entry timestamps; failsafe throttle is derived from elapsed time since entry.
    int st = MDisarmed;
    int exp_thr = 0, exp_yaw = Neutral, exp_roll = Neutral, exp_pitch = Neutral;
    int since_clear = 0, edge_n = 0, arm_start = 0, fs_entry = 0, ramp_start = 0;
    bit h1 = 0, h2 = 0, h3 = 0, sig_ok_m = 0;
    bit pwm_en = 0;
    int pwm_phase = 0;

    task automatic set_neutral();
        exp_yaw = Neutral; exp_roll = Neutral; exp_pitch = Neutral;
    endtask

    task automatic pass_inputs();
        exp_thr = int'(rc.throttle_val);
        exp_yaw = int'(rc.yaw_val); exp_roll = int'(rc.roll_val); exp_pitch = int'(rc.pitch_val);
    endtask

    task automatic model_edge();
        bit sw_on, arm_ok;
        edge_n++;
        if (!resetn) begin
            st = MDisarmed; exp_thr = 0; set_neutral();
            since_clear = 0; h1 = 0; h2 = 0; h3 = 0; sig_ok_m = 0;
            return;
        end
        sw_on  = int'(rc.swa_swb_val) >= int'(SwThresh);
        arm_ok = sig_ok_m && rc.imu_good && sw_on && (int'(rc.throttle_val) <= int'(ThrMax));
        case (st)
            MDisarmed: if (arm_ok) begin st = MArming; arm_start = edge_n; end
            MArming: begin
                if (!arm_ok) st = MDisarmed;
                else if (edge_n - arm_start == int'(Hold)) begin st = MArmed; pass_inputs(); end
            end
            MArmed: begin
                if (!sig_ok_m) begin
                    st = MFailsafe; fs_entry = edge_n; ramp_start = exp_thr; set_neutral();
                end else if (!sw_on) begin
                    st = MDisarmed; exp_thr = 0; set_neutral();
                end else begin
                    pass_inputs();
                end
            end
            MFailsafe: begin
                if (exp_thr == 0) st = MLockout;
                else exp_thr = ramp_start - (edge_n - fs_entry) / int'(Step);
            end
            MLockout: if (sig_ok_m && !sw_on) st = MDisarmed;
            default: st = MDisarmed;
        endcase
        // Signal present while fewer than Timeout cycles have passed since the last edge.
        sig_ok_m = (since_clear < int'(Timeout));
        if (h2 && !h3) since_clear = 0;
        else since_clear++;
        h3 = h2; h2 = h1; h1 = rc.throttle_pwm;
    endtask

    function automatic logic [63:0] got_vec();
        return {26'd0, rc.throttle_out, rc.yaw_out, rc.roll_out, rc.pitch_out,
                rc.armed, rc.failsafe_active, rc.signal_ok, rc.fsm_state};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {26'd0, 8'(exp_thr), 8'(exp_yaw), 8'(exp_roll), 8'(exp_pitch),
                st == MArmed, st == MFailsafe, sig_ok_m, 3'(st)};
    endfunction

    task automatic tick();
        rc.throttle_pwm = pwm_en && (pwm_phase < 2);
        pwm_phase       = (pwm_phase + 1) % PwmPeriod;
        rc.yaw_val      = 8'($urandom_range(0, 255));
        rc.roll_val     = 8'($urandom_range(0, 255));
        rc.pitch_val    = 8'($urandom_range(0, 255));
        @(posedge us_clk);
        model_edge();
        #1;
        check("cycle", got_vec(), exp_vec());
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        resetn = 1'b0;
        rc.throttle_pwm = 1'b0; rc.throttle_val = '0; rc.yaw_val = '0; rc.roll_val = '0;
        rc.pitch_val = '0; rc.swa_swb_val = '0; rc.imu_good = 1'b1;
        pwm_en = 1;

        run(3);
        check("reset_thr", 64'(rc.throttle_out), 64'd0);
        check("reset_yaw", 64'(rc.yaw_out), 64'd125);
        check("reset_state", 64'(rc.fsm_state), 64'd0);
        check("reset_sigok", 64'(rc.signal_ok), 64'd0);
        resetn = 1'b1;

        // Basic arm and pass-through.
        rc.swa_swb_val = 8'd200; rc.throttle_val = 8'd5;
        run(int'(Hold) + 40);
        check("arm_basic", 64'(rc.armed), 64'd1);
        repeat (40) begin
            rc.throttle_val = 8'($urandom_range(0, 255));
            tick();
        end
        check("armed_tracks", 64'(rc.armed), 64'd1);

        // Signal loss from throttle 100: failsafe, ramp, lockout.
        rc.throttle_val = 8'd100;
        run(3);
        pwm_en = 0;
        run(int'(Timeout) + 20);
        check("fs_entered", 64'(rc.failsafe_active), 64'd1);
        run(100 * int'(Step) + 10);
        check("lockout", 64'(rc.fsm_state), 64'd4);
        check("lockout_thr", 64'(rc.throttle_out), 64'd0);

        // Lockout holds with switch on; needs an off cycle.
        pwm_en = 1;
        run(100);
        check("lockout_hold", 64'(rc.fsm_state), 64'd4);
        rc.swa_swb_val = 8'd0;
        run(5);
        check("lockout_exit", 64'(rc.fsm_state), 64'd0);
        rc.swa_swb_val = 8'd200; rc.throttle_val = 8'd5;
        run(int'(Hold) + 10);
        check("rearm", 64'(rc.armed), 64'd1);

        // Switch off while armed, and mid-hold abort.
        rc.swa_swb_val = 8'd0;
        tick();
        check("sw_off_state", 64'(rc.fsm_state), 64'd0);
        check("sw_off_thr", 64'(rc.throttle_out), 64'd0);
        rc.swa_swb_val = 8'd200;
        run(int'(Hold) / 2);
        check("mid_hold", 64'(rc.fsm_state), 64'd1);
        rc.swa_swb_val = 8'd0;
        tick();
        check("hold_abort", 64'(rc.fsm_state), 64'd0);
        rc.swa_swb_val = 8'd200;
        run(int'(Hold));
        check("hold_restart", 64'(rc.armed), 64'd0);
        run(5);
        check("hold_done", 64'(rc.armed), 64'd1);

        // Threshold boundaries.
        rc.swa_swb_val = 8'd0;
        run(3);
        rc.throttle_val = 8'd11; rc.swa_swb_val = 8'd200;
        run(int'(Hold) + 10);
        check("thr_11_blocks", 64'(rc.fsm_state), 64'd0);
        rc.throttle_val = 8'd10; rc.swa_swb_val = 8'd128;
        run(int'(Hold) + 10);
        check("thr_10_sw_128", 64'(rc.armed), 64'd1);
        rc.swa_swb_val = 8'd127;
        tick();
        check("sw_127_off", 64'(rc.fsm_state), 64'd0);

        // Reset mid-failsafe.
        rc.swa_swb_val = 8'd200; rc.throttle_val = 8'd5;
        run(int'(Hold) + 10);
        rc.throttle_val = 8'd100;
        run(3);
        pwm_en = 0;
        run(int'(Timeout) + 20 + 20 * int'(Step));
        check("fs_before_rst", 64'(rc.failsafe_active), 64'd1);
        resetn = 1'b0;
        tick();
        check("rst_state", 64'(rc.fsm_state), 64'd0);
        check("rst_thr", 64'(rc.throttle_out), 64'd0);
        check("rst_fs", 64'(rc.failsafe_active), 64'd0);
        check("rst_pitch", 64'(rc.pitch_out), 64'd125);
        resetn = 1'b1;
        pwm_en = 1;

        // Random soak.
        repeat (4000) begin
            if ($urandom_range(0, 79) == 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    rc.throttle_val = 8'($urandom_range(0, 12));
                    rc.swa_swb_val  = 8'($urandom_range(120, 255));
                    rc.imu_good     = 1'b1;
                end else begin
                    rc.throttle_val = 8'($urandom_range(0, 255));
                    rc.swa_swb_val  = 8'($urandom_range(0, 255));
                    rc.imu_good     = 1'($urandom_range(0, 1));
                end
            end
            if (rc.armed && $urandom_range(0, 14) == 0) rc.throttle_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 399) == 0) pwm_en = !pwm_en;
            resetn = ($urandom_range(0, 1999) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
